dot_product_result_collector: RTL and testbench
===============================================

// Module: dot_product_result_collector
// PURPOSE
//  Downstream of the 16-lane row organizer. Captures each scalar dot-product result (one per matrix row) when
//  the final adder's finish pulse fires, and packs results into NO_OF_UNITS-wide vector words. Words are
//  buffered in a small FIFO and handed to the next stage (vector write-back / next iteration) via valid/ready.
// PARAMETERS
//  ELEMENT_WIDTH  32  width of one IEEE-754 single result element
//  NO_OF_UNITS    16  elements packed per output word (lane 0 = first result, in bits [ELEMENT_WIDTH-1:0])
//  NO_OF_ROWS     64  results per run; 1..4096; need not be a multiple of NO_OF_UNITS
//  FIFO_DEPTH     4   output word buffer depth; power of 2, >=2
// PORTS
//  clk           in   1                     rising-edge clock
//  main_reset_n  in   1                     asynchronous, active-low reset
//  start         in   1                     level; low = clear to IDLE (synchronous), rising -> new run
//  result_in     in   ELEMENT_WIDTH         dot-product result from final adder
//  result_valid  in   1                     1-cycle strobe: result_in valid (final_adder_finish_dash)
//  out_vector    out  NO_OF_UNITS*ELEMENT_WIDTH  packed word at FIFO head
//  out_valid     out  1                     FIFO non-empty
//  out_ready     in   1                     consumer accepts head when out_valid&&out_ready
//  out_last      out  1                     head word is last word of the run
//  collect_done  out  1                     run complete, all words drained; held until start low
//  overflow      out  1                     sticky: a word was dropped because FIFO was full
// BEHAVIOUR
//  Reset (main_reset_n=0): all outputs 0, FIFO empty, lane/row counters 0, state IDLE.
//  States: IDLE -> COLLECT (start=1) -> DRAIN (last row captured) -> DONE (FIFO empty) -> IDLE (start=0).
//   start=0 in any state -> IDLE next cycle; counters, staging word, FIFO, overflow cleared (mid-run abort).
//  COLLECT: on result_valid, write result_in into staging lane[lane_idx]; lane_idx++, row_idx++.
//   Word push when lane_idx==NO_OF_UNITS-1 or row_idx==NO_OF_ROWS-1; pushed word includes the strobed element
//   in that same cycle (no extra latency). Unfilled lanes of a partial final word are 32'h0000_0000.
//   After push lane_idx wraps to 0, staging cleared. out_last tagged on the word carrying row NO_OF_ROWS-1.
//  Latency: strobe of completing element -> out_valid high next cycle (if FIFO was empty).
//  result_valid ignored in IDLE, DRAIN, DONE (no counter movement, no overflow).
//  FIFO full on push: if pop in same cycle, push accepted; else word dropped, overflow<=1, counters advance.
//  Simultaneous push+pop when empty: pop has no effect (out_valid was 0); word enters FIFO.
//  out_vector/out_last stable while out_valid && !out_ready.
//  DRAIN -> DONE when FIFO empty; collect_done=1 in DONE only. overflow cleared only by start=0 or reset.
//  Counters: lane_idx $clog2(NO_OF_UNITS) bits, row_idx $clog2(NO_OF_ROWS+1) bits; no arithmetic on data.
// STRUCTURE
//  Shared package: ELEMENT_WIDTH/NO_OF_UNITS defaults, FP_ZERO constant, collector state encoding
//   (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2, DONE=2'd3).
//  Sub-module: result_word_fifo (sync FIFO, width NO_OF_UNITS*ELEMENT_WIDTH+1 incl. last bit, push/pop/full/
//   empty, synchronous clear). Staging register, counters and FSM live in this module.
// TESTING
//  1 NO_OF_ROWS=16, 16 strobes values 1.0..16.0, out_ready=1 -> one word, lane k = float(k+1), out_last=1,
//    collect_done=1 two cycles after last pop condition.
//  2 NO_OF_ROWS=20 -> word0 full (16 lanes), word1 lanes0-3 = results 16..19, lanes4-15 = 0, out_last only on word1.
//  3 NO_OF_ROWS=96, FIFO_DEPTH=4, out_ready=0 -> 4 words held, 5th dropped, overflow=1 and sticky; release
//    ready -> 4 words drained in order, DONE reached.
//  4 FIFO full, completing strobe in same cycle as pop -> word accepted, overflow stays 0.
//  5 start dropped after 7 strobes, then re-raised -> FIFO empty, out_valid=0, overflow=0; new run lane0 = next strobe.
//  6 main_reset_n pulsed low mid-COLLECT (async, off clock edge) -> all outputs 0 immediately; strobes while
//    start=0 or in DONE produce no words.

Source files
------------

// File: rtl/dot_product_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dot_product_result_collector_pkg
// Brief   : Shared defaults, FP zero constant and collector state encoding
//           for the dot-product result collector.
// Revision: 1.0
// ============================================================================
package dot_product_result_collector_pkg;

  localparam int ELEMENT_WIDTH_DEF = 32;
  localparam int NO_OF_UNITS_DEF   = 16;

  // IEEE-754 single +0.0, used to fill unwritten lanes of a partial word
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } collector_state_e;

endpackage
`default_nettype wire

// File: rtl/dot_product_result_collector_result_word_fifo.sv
`default_nettype none
// ============================================================================
// Module  : result_word_fifo
// Brief   : Synchronous FIFO for packed result words (word + last flag).
//           Push into a full FIFO is accepted only when a pop happens in the
//           same cycle; pop of an empty FIFO is ignored.
// Revision: 1.0
// ============================================================================
module result_word_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; DEPTH is a power of two
  // so pointers wrap by natural overflow.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage needs no reset: its contents are only visible when non-empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/dot_product_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : dot_product_result_collector
// Brief   : Captures one scalar dot-product result per row, packs them into
//           NO_OF_UNITS-wide words and hands the words downstream through a
//           small FIFO with valid/ready, tagging the run's final word.
// Revision: 1.0
// ============================================================================
module dot_product_result_collector
  import dot_product_result_collector_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int NO_OF_UNITS   = NO_OF_UNITS_DEF,
  parameter int NO_OF_ROWS    = 64,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 main_reset_n,
  input  logic                                 start,
  input  logic [ELEMENT_WIDTH-1:0]             result_in,
  input  logic                                 result_valid,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] out_vector,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 collect_done,
  output logic                                 overflow
);

  localparam int WORD_W = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam int LANE_W = $clog2(NO_OF_UNITS);
  localparam int ROW_W  = $clog2(NO_OF_ROWS + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NO_OF_UNITS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NO_OF_ROWS - 1);

  collector_state_e state_q, state_d;
  logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] staging_q, staging_d;
  logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] word_w;
  logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] zero_word;
  logic              overflow_q, overflow_d;

  logic              push_last;
  logic              word_done;
  logic              fifo_push;
  logic              fifo_clear;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W:0]   fifo_head;

  generate
    for (genvar k = 0; k < NO_OF_UNITS; k++) begin : g_zero_lane
      assign zero_word[k] = ELEMENT_WIDTH'(FP_ZERO);
    end
  endgenerate

  // Next-state, staging and push decisions; start low aborts from any state.
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    row_idx_d  = row_idx_q;
    staging_d  = staging_q;
    overflow_d = overflow_q;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;
    // The word that would be pushed includes the element strobed this cycle
    word_w             = staging_q;
    word_w[lane_idx_q] = result_in;
    push_last          = (row_idx_q == LAST_ROW);
    word_done          = (lane_idx_q == LAST_LANE) || push_last;

    if (!start) begin
      state_d    = IDLE;
      lane_idx_d = '0;
      row_idx_d  = '0;
      staging_d  = zero_word;
      overflow_d = 1'b0;
      fifo_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COLLECT;
        end
        COLLECT: begin
          if (result_valid) begin
            row_idx_d = row_idx_q + ROW_W'(1);
            if (word_done) begin
              fifo_push  = 1'b1;
              staging_d  = zero_word;
              lane_idx_d = '0;
              // Full FIFO only makes room if the head leaves this same cycle
              if (fifo_full && !out_ready) begin
                overflow_d = 1'b1;
              end
            end else begin
              staging_d  = word_w;
              lane_idx_d = lane_idx_q + LANE_W'(1);
            end
            if (push_last) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters, staging word and sticky overflow registers.
  always_ff @(posedge clk or negedge main_reset_n) begin
    if (!main_reset_n) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      row_idx_q  <= '0;
      staging_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      row_idx_q  <= row_idx_d;
      staging_q  <= staging_d;
      overflow_q <= overflow_d;
    end
  end

  result_word_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (main_reset_n),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data ({push_last, word_w}),
    .pop       (out_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head contents are forced to zero while nothing valid is presented
  assign out_valid    = !fifo_empty;
  assign out_vector   = out_valid ? fifo_head[WORD_W-1:0] : '0;
  assign out_last     = out_valid & fifo_head[WORD_W];
  assign collect_done = (state_q == DONE);
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_dot_product_result_collector
// Brief   : Randomized self-checking bench for the result collector with a
//           queue-based reference model of rows, words and FIFO occupancy.
// Revision: 1.0
// ============================================================================
module tb_dot_product_result_collector;

  localparam int EW = 32;
  localparam int U  = 16;
  localparam int R  = 100;
  localparam int D  = 4;
  localparam int WW = EW * U;

  logic          clk = 1'b0;
  logic          main_reset_n;
  logic          start;
  logic [EW-1:0] result_in;
  logic          result_valid;
  logic [WW-1:0] out_vector;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          collect_done;
  logic          overflow;

  dot_product_result_collector #(
    .ELEMENT_WIDTH (EW),
    .NO_OF_UNITS   (U),
    .NO_OF_ROWS    (R),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk          (clk),
    .main_reset_n (main_reset_n),
    .start        (start),
    .result_in    (result_in),
    .result_valid (result_valid),
    .out_vector   (out_vector),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .collect_done (collect_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words waiting downstream, elements of the word being built
  logic [WW:0]   m_q[$];
  logic [EW-1:0] m_cur[$];
  int            m_rows;
  bit            m_active;
  bit            m_done;
  bit            m_ovf;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur.delete();
    m_rows   = 0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge
  task automatic model_edge();
    int          pre;
    bit          pop;
    logic [WW:0] w;
    if (!main_reset_n || !start) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      m_active = 1'b1;
      return;
    end
    pre = m_q.size();
    pop = out_ready && (pre > 0);
    if (pop) void'(m_q.pop_front());
    if (m_rows < R) begin
      if (result_valid) begin
        m_cur.push_back(result_in);
        m_rows++;
        if (m_cur.size() == U || m_rows == R) begin
          w = '0;
          foreach (m_cur[k]) w[k*EW +: EW] = m_cur[k];
          w[WW] = (m_rows == R);
          if (pre < D || pop) m_q.push_back(w);
          else m_ovf = 1'b1;
          m_cur.delete();
        end
      end
    end else if (!m_done && pre == 0) begin
      m_done = 1'b1;
    end
  endtask

  task automatic compare();
    logic [WW:0] h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    check("out_valid",    WW'(out_valid),    WW'(m_q.size() > 0));
    check("out_vector",   out_vector,        h[WW-1:0]);
    check("out_last",     WW'(out_last),     WW'(h[WW]));
    check("collect_done", WW'(collect_done), WW'(m_done));
    check("overflow",     WW'(overflow),     WW'(m_ovf));
  endtask

  task automatic cycle(input bit s, input bit rv, input bit rdy);
    start        = s;
    result_valid = rv;
    result_in    = $urandom;
    out_ready    = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  // Keep start high until the run completes (or all rows are in), bounded
  task automatic run(input int rv_pct, input int rdy_pct, input bit stop_at_rows);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b1, pct(rv_pct), pct(rdy_pct));
      if (stop_at_rows && m_rows == R) begin
        reached = 1'b1;
        break;
      end
      if (!stop_at_rows && m_done && collect_done) begin
        reached = 1'b1;
        break;
      end
    end
    check("run_timeout", WW'(reached), WW'(1));
  endtask

  initial begin
    main_reset_n = 1'b0;
    start        = 1'b0;
    result_valid = 1'b0;
    result_in    = '0;
    out_ready    = 1'b0;
    model_reset();
    #12;
    compare();
    main_reset_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b1, 1'b1);

    // Sparse strobes, consumer always ready; then strobes in DONE and with start low
    run(50, 100, 1'b0);
    repeat (5) cycle(1'b1, pct(60), 1'b1);
    check("done_held", WW'(collect_done), WW'(1));
    repeat (3) cycle(1'b0, 1'b1, 1'b1);

    // Consumer stalled: FIFO fills, later words dropped, overflow sticks
    run(100, 0, 1'b1);
    check("ovf_set", WW'(overflow), WW'(1));
    repeat (4) cycle(1'b1, 1'b1, 1'b0);
    check("ovf_sticky", WW'(overflow), WW'(1));
    run(30, 100, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    check("ovf_cleared", WW'(overflow), WW'(0));

    // FIFO full, completing strobe coincides with a pop
    cycle(1'b1, 1'b0, 1'b0);
    repeat (79) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("full_pop_push_ovf", WW'(overflow), WW'(0));
    run(100, 100, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Abort after 7 strobes, then a fresh run
    cycle(1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    check("abort_valid", WW'(out_valid), WW'(0));
    run(70, 60, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-collect, away from the clock edge
    cycle(1'b1, 1'b0, 1'b0);
    repeat (30) cycle(1'b1, 1'b1, 1'b0);
    #2;
    main_reset_n = 1'b0;
    model_reset();
    #1;
    compare();
    check("async_rst_valid", WW'(out_valid), WW'(0));
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    main_reset_n = 1'b1;
    run(80, 50, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Random mixes
    for (int r = 0; r < 3; r++) begin
      run($urandom_range(90, 20), $urandom_range(100, 10), 1'b0);
      repeat (3) cycle(1'b1, pct(50), pct(50));
      repeat (2) cycle(1'b0, pct(50), pct(50));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
